// File: rtl/schmidl_cox_pkg.sv
// Shared types and default widths for the Schmidl-Cox timing-metric peak detector.
package schmidl_cox_pkg;

  localparam int unsigned SC_METRIC_W = 32;
  localparam int unsigned SC_CNT_W    = 32;
  localparam int unsigned SC_LEN_W    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPlateau,
    StHoldoff
  } sc_det_state_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// One-deep AXI-Stream register; accepts a new beat whenever the held one is leaving or absent.
module axis_pipe_reg #(
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [DataW-1:0] in_data_i,
  input  logic             in_last_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [DataW-1:0] out_data_o,
  output logic             out_last_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [DataW-1:0] data_q, data_d;

  assign in_ready_o = rst_ni && !clear_i && (out_ready_i || !valid_q);

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
        last_d = in_last_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/schmidl_cox_peak_detector.sv
// Forwards the timing-metric stream and reports the peak of each qualifying above-threshold run.
module schmidl_cox_peak_detector
  import schmidl_cox_pkg::*;
#(
  parameter int unsigned METRIC_W = SC_METRIC_W,
  parameter int unsigned CNT_W    = SC_CNT_W,
  parameter int unsigned LEN_W    = SC_LEN_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [METRIC_W-1:0] threshold,
  input  logic [LEN_W-1:0]    min_len,
  input  logic [LEN_W-1:0]    max_len,
  input  logic [LEN_W-1:0]    holdoff,
  input  logic [METRIC_W-1:0] i_tdata,
  input  logic                i_tlast,
  input  logic                i_tvalid,
  output logic                i_tready,
  output logic [METRIC_W-1:0] o_tdata,
  output logic                o_tlast,
  output logic                o_tvalid,
  input  logic                o_tready,
  output logic                o_peak_valid,
  output logic [CNT_W-1:0]    o_peak_index,
  output logic [METRIC_W-1:0] o_peak_metric,
  output logic                o_det_active
);

  sc_det_state_t state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d, hcnt_q, hcnt_d, len_inc, min_eff;
  logic [METRIC_W-1:0] best_q, best_d, det_metric, peak_metric_q, peak_metric_d;
  logic [CNT_W-1:0]    best_idx_q, best_idx_d, cnt_q, cnt_d, det_index, peak_index_q, peak_index_d;
  logic                accept, above, detect;
  logic                peak_valid_q, peak_valid_d, det_active_q, det_active_d;

  axis_pipe_reg #(
    .DataW(METRIC_W)
  ) u_pipe (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .clear_i    (clear),
    .in_data_i  (i_tdata),
    .in_last_i  (i_tlast),
    .in_valid_i (i_tvalid),
    .in_ready_o (i_tready),
    .out_data_o (o_tdata),
    .out_last_o (o_tlast),
    .out_valid_o(o_tvalid),
    .out_ready_i(o_tready)
  );

  assign accept  = i_tvalid && i_tready;
  assign above   = i_tdata > threshold;
  assign len_inc = (&len_q) ? len_q : len_q + LEN_W'(1);
  assign min_eff = (min_len == '0) ? LEN_W'(1) : min_len;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    hcnt_d     = hcnt_q;
    detect     = 1'b0;
    cnt_d      = accept ? cnt_q + CNT_W'(1) : cnt_q;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (above) begin
            state_d    = StPlateau;
            len_d      = LEN_W'(1);
            best_d     = i_tdata;
            best_idx_d = cnt_q;
          end
        end
        StPlateau: begin
          if (above) begin
            len_d = len_inc;
            // Strict compare keeps the earliest beat on a tie.
            if (i_tdata > best_q) begin
              best_d     = i_tdata;
              best_idx_d = cnt_q;
            end
            if ((max_len != '0) && (len_inc == max_len)) detect = 1'b1;
          end else if (len_q >= min_eff) begin
            detect = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        StHoldoff: begin
          hcnt_d = hcnt_q - LEN_W'(1);
          if (hcnt_q == LEN_W'(1)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    if (detect) begin
      if (holdoff == '0) begin
        state_d = StIdle;
      end else begin
        state_d = StHoldoff;
        hcnt_d  = holdoff;
      end
    end
  end

  always_comb begin
    det_metric    = best_d;
    det_index     = best_idx_d;
    det_active_d  = (state_d == StPlateau);
    peak_valid_d  = detect;
    peak_index_d  = detect ? det_index : peak_index_q;
    peak_metric_d = detect ? det_metric : peak_metric_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      len_q         <= '0;
      hcnt_q        <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      cnt_q         <= '0;
      peak_valid_q  <= 1'b0;
      peak_index_q  <= '0;
      peak_metric_q <= '0;
      det_active_q  <= 1'b0;
    end else begin
      len_q         <= len_d;
      hcnt_q        <= hcnt_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      cnt_q         <= cnt_d;
      peak_valid_q  <= peak_valid_d;
      peak_index_q  <= peak_index_d;
      peak_metric_q <= peak_metric_d;
      det_active_q  <= det_active_d;
    end
  end

  assign o_peak_valid  = peak_valid_q;
  assign o_peak_index  = peak_index_q;
  assign o_peak_metric = peak_metric_q;
  assign o_det_active  = det_active_q;

endmodule
